// File: rtl/pulse_rate_counter.sv
// Pulse rate counter: counts rising edges of pulse_in over a gate window of
// GATE_CYCLES enabled cycles, with a detector dead time after each accepted
// event, saturating count, and a valid/ready result handshake with a sticky
// overrun flag when a finished window finds the previous result unconsumed.
module pulse_rate_counter #(
    parameter int GATE_CYCLES = 1000,
    parameter int DEAD_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] count_out,
    output logic             count_sat,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             overrun
);

    localparam int GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int DEAD_W = (DEAD_CYCLES > 0) ? $clog2(DEAD_CYCLES + 1) : 1;

    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    logic              pulse_prev_q;
    logic [GATE_W-1:0] gate_q,      gate_d;
    logic [DEAD_W-1:0] dead_q,      dead_d;
    logic [CNT_W-1:0]  win_cnt_q,   win_cnt_d;
    logic              win_sat_q,   win_sat_d;
    logic [CNT_W-1:0]  count_out_q, count_out_d;
    logic              count_sat_q, count_sat_d;
    logic              valid_q,     valid_d;
    logic              overrun_q,   overrun_d;

    logic              evt;
    logic              acc;
    logic              close;
    logic              load;
    logic              drop;
    logic [CNT_W-1:0]  res_cnt;
    logic              res_sat;

    // Event detection, dead time, gate timing and window result, plus the
    // output handshake decisions taken at window close.
    always_comb begin
        evt     = pulse_in & ~pulse_prev_q;
        acc     = evt & ena & (dead_q == '0);
        close   = ena & (gate_q == GATE_LAST);

        // Result includes an event accepted in the close cycle itself.
        res_cnt = win_cnt_q;
        res_sat = win_sat_q;
        if (acc) begin
            if (win_cnt_q == CNT_MAX) begin
                res_sat = 1'b1;
            end else begin
                res_cnt = win_cnt_q + CNT_W'(1);
            end
        end

        win_cnt_d = close ? '0   : res_cnt;
        win_sat_d = close ? 1'b0 : res_sat;

        gate_d = gate_q;
        if (ena) begin
            gate_d = close ? '0 : gate_q + GATE_W'(1);
        end

        // Dead time is never cleared by window close; it spans boundaries.
        dead_d = dead_q;
        if (ena) begin
            if (acc) begin
                dead_d = DEAD_LOAD;
            end else if (dead_q != '0) begin
                dead_d = dead_q - DEAD_W'(1);
            end
        end

        load = close & (~valid_q | count_ready);
        drop = close & valid_q & ~count_ready;

        count_out_d = load ? res_cnt : count_out_q;
        count_sat_d = load ? res_sat : count_sat_q;
        if (load) begin
            valid_d = 1'b1;
        end else if (valid_q & count_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
        overrun_d = overrun_q | drop;
    end

    // Window measurement state: edge history, gate timer, dead timer, count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_prev_q <= 1'b0;
            gate_q       <= '0;
            dead_q       <= '0;
            win_cnt_q    <= '0;
            win_sat_q    <= 1'b0;
        end else begin
            pulse_prev_q <= pulse_in;
            gate_q       <= gate_d;
            dead_q       <= dead_d;
            win_cnt_q    <= win_cnt_d;
            win_sat_q    <= win_sat_d;
        end
    end

    // Result register and handshake; independent of ena.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_out_q <= '0;
            count_sat_q <= 1'b0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            count_out_q <= count_out_d;
            count_sat_q <= count_sat_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign count_out   = count_out_q;
    assign count_sat   = count_sat_q;
    assign count_valid = valid_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_pulse_rate_counter.sv
// Bench for pulse_rate_counter: three instances sharing stimulus
// (gate 16/dead 3, gate 16/dead 0, gate 40/dead 0, all 4-bit counts),
// directed scenarios plus randomized traffic against an event-list model.
module tb_pulse_rate_counter;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    logic pulse_in;
    logic count_ready;

    logic [11:0] cnt_all;
    logic [2:0]  sat_all;
    logic [2:0]  vld_all;
    logic [2:0]  ovr_all;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pulse_rate_counter #(.GATE_CYCLES(16), .DEAD_CYCLES(3), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse_in),
        .count_out(cnt_all[3:0]), .count_sat(sat_all[0]), .count_valid(vld_all[0]),
        .count_ready(count_ready), .overrun(ovr_all[0]));

    pulse_rate_counter #(.GATE_CYCLES(16), .DEAD_CYCLES(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse_in),
        .count_out(cnt_all[7:4]), .count_sat(sat_all[1]), .count_valid(vld_all[1]),
        .count_ready(count_ready), .overrun(ovr_all[1]));

    pulse_rate_counter #(.GATE_CYCLES(40), .DEAD_CYCLES(0), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst), .ena(ena), .pulse_in(pulse_in),
        .count_out(cnt_all[11:8]), .count_sat(sat_all[2]), .count_valid(vld_all[2]),
        .count_ready(count_ready), .overrun(ovr_all[2]));

    // Reference model: per instance, events are numbered by enabled-cycle
    // index; an event is accepted when more than DEAD enabled cycles have
    // passed since the last accepted one. Windows are fixed blocks of G
    // enabled cycles; the result is the clamped number of accepted events.
    int G [3] = '{16, 16, 40};
    int D [3] = '{3, 0, 0};
    int m_ena  [3];
    int m_last [3];
    int m_win  [3];
    bit m_prev;
    bit ev   [3];
    int eo   [3];
    bit es   [3];
    bit eovr [3];

    task automatic model_reset();
        m_prev = 1'b0;
        for (int c = 0; c < 3; c++) begin
            m_ena[c]  = 0;
            m_last[c] = -1000;
            m_win[c]  = 0;
            ev[c]     = 1'b0;
            eo[c]     = 0;
            es[c]     = 1'b0;
            eovr[c]   = 1'b0;
        end
    endtask

    task automatic model_update(input bit p, input bit e, input bit r);
        bit evt;
        bit close;
        bit rs;
        int res;
        evt    = p && !m_prev;
        m_prev = p;
        for (int c = 0; c < 3; c++) begin
            close = 1'b0;
            rs    = 1'b0;
            res   = 0;
            if (e) begin
                if (evt && (m_ena[c] - m_last[c] > D[c])) begin
                    m_win[c]++;
                    m_last[c] = m_ena[c];
                end
                if (m_ena[c] % G[c] == G[c] - 1) begin
                    close    = 1'b1;
                    rs       = (m_win[c] > 15);
                    res      = rs ? 15 : m_win[c];
                    m_win[c] = 0;
                end
                m_ena[c]++;
            end
            if (close) begin
                if (!ev[c] || r) begin
                    ev[c] = 1'b1;
                    eo[c] = res;
                    es[c] = rs;
                end else begin
                    eovr[c] = 1'b1;
                end
            end else if (ev[c] && r) begin
                ev[c] = 1'b0;
            end
        end
    endtask

    task automatic step(input bit p, input bit e, input bit r);
        pulse_in    = p;
        ena         = e;
        count_ready = r;
        @(posedge clk);
        model_update(p, e, r);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        pulse_in    = 1'b0;
        ena         = 1'b0;
        count_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (cnt_all[c*4 +: 4] !== 4'd0) begin
                n_fail++; $display("FAIL reset_cnt[%0d]: got %0d expected 0", c, cnt_all[c*4 +: 4]);
            end
            n_tests++;
            if ({sat_all[c], vld_all[c], ovr_all[c]} !== 3'b000) begin
                n_fail++; $display("FAIL reset_flags[%0d]: got sat/vld/ovr %b expected 000", c,
                                   {sat_all[c], vld_all[c], ovr_all[c]});
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        for (int k = 0; k < 15; k++) step(k == 2 || k == 8 || k == 14, 1'b1, 1'b1);
        n_tests++;
        if (vld_all[0] !== 1'b0) begin
            n_fail++; $display("FAIL basic_early_valid: got %b expected 0", vld_all[0]);
        end
        step(1'b0, 1'b1, 1'b1);
        n_tests++;
        if (vld_all[0] !== 1'b1 || cnt_all[3:0] !== 4'd3 || sat_all[0] !== 1'b0) begin
            n_fail++; $display("FAIL basic_result: got vld=%b cnt=%0d sat=%b expected vld=1 cnt=3 sat=0",
                               vld_all[0], cnt_all[3:0], sat_all[0]);
        end
        n_tests++;
        if (cnt_all[7:4] !== 4'd3) begin
            n_fail++; $display("FAIL basic_nodead: got %0d expected 3", cnt_all[7:4]);
        end
        step(1'b0, 1'b1, 1'b1);
        n_tests++;
        if (vld_all[0] !== 1'b0) begin
            n_fail++; $display("FAIL basic_valid_one_cycle: got %b expected 0", vld_all[0]);
        end
    endtask

    task automatic test_dead_time();
        do_reset();
        for (int k = 0; k < 16; k++) step(k == 2 || k == 4 || k == 6, 1'b1, 1'b1);
        n_tests++;
        if (cnt_all[3:0] !== 4'd2) begin
            n_fail++; $display("FAIL dead3_cnt: got %0d expected 2", cnt_all[3:0]);
        end
        n_tests++;
        if (cnt_all[7:4] !== 4'd3) begin
            n_fail++; $display("FAIL dead0_cnt: got %0d expected 3", cnt_all[7:4]);
        end
    endtask

    task automatic test_held_high();
        do_reset();
        for (int k = 0; k < 16; k++) step(1'b1, 1'b1, 1'b1);
        n_tests++;
        if (cnt_all[3:0] !== 4'd1 || cnt_all[7:4] !== 4'd1) begin
            n_fail++; $display("FAIL held_cnt: got a=%0d b=%0d expected 1 1", cnt_all[3:0], cnt_all[7:4]);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            step(k % 2 == 0, 1'b1, 1'b1);
            if (k == 15) begin
                n_tests++;
                if (vld_all[1] !== 1'b1 || cnt_all[7:4] !== 4'd8 || sat_all[1] !== 1'b0) begin
                    n_fail++; $display("FAIL alt_cnt: got vld=%b cnt=%0d sat=%b expected 1 8 0",
                                       vld_all[1], cnt_all[7:4], sat_all[1]);
                end
            end
        end
        n_tests++;
        if (vld_all[2] !== 1'b1 || cnt_all[11:8] !== 4'd15 || sat_all[2] !== 1'b1) begin
            n_fail++; $display("FAIL sat_cnt: got vld=%b cnt=%0d sat=%b expected 1 15 1",
                               vld_all[2], cnt_all[11:8], sat_all[2]);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        for (int k = 0; k < 32; k++) step(k == 2 || k == 8 || k == 18 || k == 24 || k == 30, 1'b1, 1'b0);
        n_tests++;
        if (vld_all[0] !== 1'b1 || cnt_all[3:0] !== 4'd2 || ovr_all[0] !== 1'b1) begin
            n_fail++; $display("FAIL ovr_hold: got vld=%b cnt=%0d ovr=%b expected 1 2 1",
                               vld_all[0], cnt_all[3:0], ovr_all[0]);
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1);
        n_tests++;
        if (vld_all[0] !== 1'b0 || ovr_all[0] !== 1'b1) begin
            n_fail++; $display("FAIL ovr_sticky: got vld=%b ovr=%b expected 0 1", vld_all[0], ovr_all[0]);
        end
        do_reset();
        for (int k = 0; k < 32; k++) step(k == 2 || k == 18 || k == 24, 1'b1, k == 31);
        n_tests++;
        if (vld_all[0] !== 1'b1 || cnt_all[3:0] !== 4'd2 || ovr_all[0] !== 1'b0) begin
            n_fail++; $display("FAIL ready_at_close: got vld=%b cnt=%0d ovr=%b expected 1 2 0",
                               vld_all[0], cnt_all[3:0], ovr_all[0]);
        end
    endtask

    task automatic test_ena_gap();
        do_reset();
        for (int k = 0; k < 5; k++) step(k == 2, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(i % 2 == 0, 1'b0, 1'b1);
        for (int k = 5; k < 15; k++) begin
            step(k == 8, 1'b1, 1'b1);
            n_tests++;
            if (vld_all[0] !== 1'b0) begin
                n_fail++; $display("FAIL gap_early_close[%0d]: got vld=%b expected 0", k, vld_all[0]);
            end
        end
        step(1'b0, 1'b1, 1'b1);
        n_tests++;
        if (vld_all[0] !== 1'b1 || cnt_all[3:0] !== 4'd2 || cnt_all[7:4] !== 4'd2) begin
            n_fail++; $display("FAIL gap_result: got vld=%b a=%0d b=%0d expected 1 2 2",
                               vld_all[0], cnt_all[3:0], cnt_all[7:4]);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int k = 0; k < 16; k++) step(k == 2, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++) step(k == 2 || k == 5, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_tests++;
            if (cnt_all[c*4 +: 4] !== 4'd0 || {sat_all[c], vld_all[c], ovr_all[c]} !== 3'b000) begin
                n_fail++; $display("FAIL async_rst[%0d]: got cnt=%0d sat/vld/ovr=%b expected 0 000", c,
                                   cnt_all[c*4 +: 4], {sat_all[c], vld_all[c], ovr_all[c]});
            end
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 16; k++) step(k == 3 || k == 10, 1'b1, 1'b1);
        n_tests++;
        if (vld_all[0] !== 1'b1 || cnt_all[3:0] !== 4'd2 || cnt_all[7:4] !== 4'd2) begin
            n_fail++; $display("FAIL post_rst_window: got vld=%b a=%0d b=%0d expected 1 2 2",
                               vld_all[0], cnt_all[3:0], cnt_all[7:4]);
        end
    endtask

    task automatic test_random();
        bit p;
        bit e;
        bit r;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            p = ($urandom_range(0, 2) == 0);
            e = ($urandom_range(0, 7) != 0);
            if ((i / 200) % 3 == 1) r = ($urandom_range(0, 9) == 0);
            else                    r = ($urandom_range(0, 3) != 0);
            step(p, e, r);
            for (int c = 0; c < 3; c++) begin
                n_tests++;
                if (vld_all[c] !== ev[c] || ovr_all[c] !== eovr[c] ||
                    cnt_all[c*4 +: 4] !== 4'(eo[c]) || sat_all[c] !== es[c]) begin
                    n_fail++;
                    $display("FAIL random[%0d] dut%0d: got vld=%b cnt=%0d sat=%b ovr=%b expected vld=%b cnt=%0d sat=%b ovr=%b",
                             i, c, vld_all[c], cnt_all[c*4 +: 4], sat_all[c], ovr_all[c],
                             ev[c], eo[c], es[c], eovr[c]);
                end
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        ena         = 1'b0;
        pulse_in    = 1'b0;
        count_ready = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_dead_time();
        test_held_high();
        test_saturate();
        test_overrun();
        test_ena_gap();
        test_rst_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pulse_rate_counter.md
PULSE_RATE_COUNTER -- requirements
Module: pulse_rate_counter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 1000: gate window length in clock cycles, legal range >= 2.
REQ-002 SHALL have parameter DEAD_CYCLES, default 4: detector dead time in cycles after each accepted event, legal range >= 0.
REQ-003 SHALL have parameter CNT_W, default 16: width of the event count.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ena  input  1  enable; low freezes gate timer, window count and dead-time timer.
REQ-007 pulse_in  input  1  event input from the upstream random pulse generator, synchronous to clk.
REQ-008 count_out  output  CNT_W  count of the last completed window.
REQ-009 count_sat  output  1  high when count_out saturated at 2^CNT_W-1.
REQ-010 count_valid  output  1  count_out/count_sat hold a result not yet consumed.
REQ-011 count_ready  input  1  consumer accepts the result.
REQ-012 overrun  output  1  sticky; a window result was discarded.

Function
REQ-013 Event: pulse_in high while pulse_prev low; pulse_prev SHALL register pulse_in every cycle regardless of ena.
REQ-014 Accepted event: event AND ena AND dead-time timer zero; only accepted events SHALL increment the window count.
REQ-015 Accepted event SHALL load the dead-time timer with DEAD_CYCLES; timer SHALL decrement by 1 per ena cycle to 0; DEAD_CYCLES=0 disables dead time.
REQ-016 Window count SHALL saturate at 2^CNT_W-1 and set an internal sat flag for the window; no wrap.
REQ-017 Gate timer SHALL count 0..GATE_CYCLES-1 on ena cycles and wrap to 0; the ena cycle with timer = GATE_CYCLES-1 is the close cycle.
REQ-018 Close cycle SHALL produce result = window count including an accepted event in that same cycle; window count and sat flag SHALL be 0 in the following cycle.
REQ-019 Dead-time timer SHALL NOT reset at window close; dead time spans window boundaries.
REQ-020 At close, if count_valid low, or count_valid and count_ready both high, count_out/count_sat SHALL load the result and count_valid SHALL be high next cycle.
REQ-021 At close, if count_valid high and count_ready low, result SHALL be discarded, held output unchanged, overrun set.
REQ-022 count_valid SHALL clear the cycle after count_valid AND count_ready unless a load occurs that cycle; count_out SHALL be stable while count_valid high and not handshaken.
REQ-023 Output latency: count_valid rises exactly 1 cycle after the close cycle.
REQ-024 ena low SHALL NOT affect the output handshake; a held result remains consumable.
REQ-025 overrun SHALL stay high until rst.

Reset
REQ-026 rst high SHALL immediately set count_out=0, count_sat=0, count_valid=0, overrun=0, gate timer=0, window count=0, dead-time timer=0, pulse_prev=0.
REQ-027 rst asserted mid-window SHALL discard the partial window; first window after release spans a full GATE_CYCLES ena cycles.

Verification (GATE_CYCLES=16, DEAD_CYCLES=3, CNT_W=4 unless stated)
REQ-028 ena=1, ready=1, 1-cycle pulses at cycles 2, 8, 14 of window -> count_out=3, count_sat=0, valid for one cycle, 1 cycle after close.
REQ-029 pulses at window cycles 2, 4, 6 (gaps < DEAD_CYCLES+1) -> only 2 and 6 accepted, count_out=2; DEAD_CYCLES=0 -> count_out=3.
REQ-030 pulse_in held high entire window -> count_out=1 (single rising edge); alternating 1/0 every cycle, DEAD_CYCLES=0 -> 8 events, count_out=8; with GATE_CYCLES=40, 20 events -> count_out=15, count_sat=1.
REQ-031 ready=0 for two windows -> first result held, second discarded, overrun=1 and sticky after ready returns; ready=1 in a close cycle with valid high -> no overrun, new result loaded.
REQ-032 ena low for 10 cycles mid-window with pulses during it -> pulses ignored, window closes 10 cycles late, count unchanged by the gap.
REQ-033 rst asserted at window cycle 9 with count 2 -> all outputs 0 asynchronously; next result counts only post-release events over 16 cycles.
